// File: rtl/axis_uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_uart_tx_arbiter_pkg
// Shared UART package: transceiver defaults plus the arbiter FSM state type.
// No ports. Imported by the arbiter top and by its testbench.
// -----------------------------------------------------------------------------
package axis_uart_tx_arbiter_pkg;

   // Transceiver defaults used by the UART transmitter behind the arbiter.
   localparam int unsigned UART_DATA_BITS        = 8;
   localparam int unsigned UART_STOP_BITS        = 1;
   localparam int unsigned UART_BAUD_DIV_DEFAULT = 868;

   // Arbiter packet FSM.
   //   ST_IDLE   : no packet in flight, one-cycle round-robin arbitration
   //   ST_HEADER : emitting the source-index header beat
   //   ST_DATA   : forwarding the granted port until its tlast beat
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_uart_tx_arbiter_if
// AXI-stream bundle with LANES parallel lanes of DATA_W bits each. The
// requester side of the arbiter uses LANES=NUM_PORTS, the transmitter side
// uses LANES=1.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high for that lane. Once tvalid is raised the source holds tdata and
// tlast unchanged and keeps tvalid high until the beat transfers; tready may
// change freely and never depends combinationally on a later tvalid.
//
// Signals:
//   tdata  [LANES*DATA_W] lane i at [i*DATA_W +: DATA_W]
//   tvalid [LANES]        source has a beat
//   tlast  [LANES]        beat is the last of its packet
//   tready [LANES]        sink accepts the beat
// Modports: master (drives data), slave (drives tready).
// -----------------------------------------------------------------------------
interface axis_uart_tx_arbiter_if #(
   parameter int LANES  = 1,
   parameter int DATA_W = 32
);
   logic [LANES*DATA_W-1:0] tdata;
   logic [LANES-1:0]        tvalid;
   logic [LANES-1:0]        tlast;
   logic [LANES-1:0]        tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_uart_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches req upward from pointer with
// wrap-around and reports the first set index.
// Ports:
//   req     [NUM_PORTS]          request bits
//   pointer [$clog2(NUM_PORTS)]  index with highest priority
//   grant   [$clog2(NUM_PORTS)]  selected index (0 when valid=0)
//   valid                        at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0]         req,
   input  logic [$clog2(NUM_PORTS)-1:0] pointer,
   output logic [$clog2(NUM_PORTS)-1:0] grant,
   output logic                         valid
);
   localparam int IW = $clog2(NUM_PORTS);

   always_comb begin
      int idx;
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         // pointer + k folded back into 0..NUM_PORTS-1 (works for non powers of two)
         idx = int'(pointer) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!valid && req[IW'(idx)]) begin
            valid = 1'b1;
            grant = IW'(idx);
         end
      end
   end
endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// axis_uart_tx_arbiter
// Packet-level round-robin arbiter merging NUM_PORTS AXI-stream requesters
// onto one stream feeding a UART transmitter. A grant lasts a whole packet;
// with ID_HEADER=1 each packet is preceded by one beat carrying the source
// index.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   s              requester streams (slave modport, NUM_PORTS lanes)
//   m              transmitter stream (master modport, 1 lane)
//   grant_id       currently / most recently granted port
//   busy           high whenever the FSM is not idle
//   state_dbg      current FSM state
// -----------------------------------------------------------------------------
module axis_uart_tx_arbiter
   import axis_uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int ID_HEADER      = 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   axis_uart_tx_arbiter_if.slave         s,
   axis_uart_tx_arbiter_if.master        m,
   output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
   output logic                          busy,
   output arb_state_t                    state_dbg
);
   localparam int GW = $clog2(NUM_PORTS);

   arb_state_t                state_q, state_d;
   logic [GW-1:0]             grant_q, grant_d;
   logic [GW-1:0]             ptr_q, ptr_d;
   logic [GW-1:0]             arb_grant;
   logic                      arb_valid;

   logic [AXI_DATA_WIDTH-1:0] sel_tdata;
   logic                      sel_tvalid;
   logic                      sel_tlast;

   logic [AXI_DATA_WIDTH-1:0] m_tdata_c;
   logic                      m_tvalid_c;
   logic                      m_tlast_c;
   logic [NUM_PORTS-1:0]      s_tready_c;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
      .req     (s.tvalid),
      .pointer (ptr_q),
      .grant   (arb_grant),
      .valid   (arb_valid)
   );

   // Lane selected by the held grant.
   always_comb begin
      sel_tdata  = '0;
      sel_tvalid = 1'b0;
      sel_tlast  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q == GW'(i)) begin
            sel_tdata  = s.tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            sel_tvalid = s.tvalid[i];
            sel_tlast  = s.tlast[i];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      m_tdata_c  = '0;
      m_tvalid_c = 1'b0;
      m_tlast_c  = 1'b0;
      s_tready_c = '0;
      unique case (state_q)
         ST_IDLE: begin
            // Grant cycle: nothing is transferred, the pointer moves past the winner.
            if (arb_valid) begin
               grant_d = arb_grant;
               ptr_d   = (arb_grant == GW'(NUM_PORTS - 1)) ? '0 : arb_grant + 1'b1;
               state_d = (ID_HEADER != 0) ? ST_HEADER : ST_DATA;
            end
         end
         ST_HEADER: begin
            m_tvalid_c = 1'b1;
            m_tdata_c  = AXI_DATA_WIDTH'(grant_q);
            if (m.tready[0]) state_d = ST_DATA;
         end
         ST_DATA: begin
            m_tdata_c  = sel_tdata;
            m_tvalid_c = sel_tvalid;
            m_tlast_c  = sel_tlast;
            for (int i = 0; i < NUM_PORTS; i++) begin
               s_tready_c[i] = (grant_q == GW'(i)) && m.tready[0];
            end
            if (sel_tvalid && m.tready[0] && sel_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m.tdata     = m_tdata_c;
   assign m.tvalid    = m_tvalid_c;
   assign m.tlast     = m_tlast_c;
   assign s.tready    = s_tready_c;
   assign grant_id    = grant_q;
   assign busy        = (state_q != ST_IDLE);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_uart_tx_arbiter
// Self-checking bench: a packet-level round-robin model builds the expected
// output beat stream; directed scenarios and randomized traffic are compared
// beat by beat. A second instance with ID_HEADER=0 covers headerless mode.
// -----------------------------------------------------------------------------
module tb_axis_uart_tx_arbiter;
   import axis_uart_tx_arbiter_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic       aclk;
   logic       aresetn;
   logic [1:0] grant_id, grant_id2;
   logic       busy, busy2;
   arb_state_t state_dbg, state_dbg2;

   axis_uart_tx_arbiter_if #(.LANES(N), .DATA_W(W)) s_if  ();
   axis_uart_tx_arbiter_if #(.LANES(1), .DATA_W(W)) m_if  ();
   axis_uart_tx_arbiter_if #(.LANES(N), .DATA_W(W)) s2_if ();
   axis_uart_tx_arbiter_if #(.LANES(1), .DATA_W(W)) m2_if ();

   axis_uart_tx_arbiter #(.NUM_PORTS(N), .AXI_DATA_WIDTH(W), .ID_HEADER(1)) dut (
      .aclk(aclk), .aresetn(aresetn), .s(s_if), .m(m_if),
      .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
   );

   axis_uart_tx_arbiter #(.NUM_PORTS(N), .AXI_DATA_WIDTH(W), .ID_HEADER(0)) dut_nohdr (
      .aclk(aclk), .aresetn(aresetn), .s(s2_if), .m(m2_if),
      .grant_id(grant_id2), .busy(busy2), .state_dbg(state_dbg2)
   );

   // ---------------- clock ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // ---------------- bench state ----------------
   int errors = 0;
   int checks = 0;

   logic [W-1:0] src_data_q[N][$];   // what each source still has to send
   logic         src_last_q[N][$];
   logic [W-1:0] mdl_data_q[N][$];   // model copy, consumed by build_expected
   logic         mdl_last_q[N][$];
   logic [W-1:0] exp_q[$];           // expected output beats
   logic         exp_last_q[$];
   int           exp_gnt_q[$];
   int           obs_gnt_q[$];
   int           model_ptr;

   bit           port_sop[N];
   bit           port_hold[N];
   int           rdy_cnt[N];
   bit           stall_prev;
   logic [W-1:0] prev_data;
   logic         prev_last;
   bit           bubble_en;
   int           tready_mode;        // 0 always ready, 1 random, 2 toggle
   bit           toggle;
   int           gap_port;
   int           gap_cnt;
   bit           gap_arm;
   int           busy_cycles;
   int           out_count;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         src_data_q[i].delete(); src_last_q[i].delete();
         mdl_data_q[i].delete(); mdl_last_q[i].delete();
         port_sop[i] = 1'b1; port_hold[i] = 1'b0; rdy_cnt[i] = 0;
      end
      exp_q.delete(); exp_last_q.delete(); exp_gnt_q.delete(); obs_gnt_q.delete();
      stall_prev = 1'b0; gap_port = -1; gap_cnt = 0; gap_arm = 1'b0;
      busy_cycles = 0; out_count = 0; toggle = 1'b1;
      s_if.tvalid = '0; s_if.tlast = '0; s_if.tdata = '0;
      m_if.tready = '0;
   endtask

   task automatic add_packet(input int port, input int len);
      logic [W-1:0] d;
      for (int b = 0; b < len; b++) begin
         d = $urandom;
         src_data_q[port].push_back(d);   src_last_q[port].push_back(b == len - 1);
         mdl_data_q[port].push_back(d);   mdl_last_q[port].push_back(b == len - 1);
      end
   endtask

   // Packet-level reference: every loaded port requests; winner is the first
   // non-empty port from the pointer; a header beat then the whole packet.
   task automatic build_expected();
      int  g;
      bit  last;
      forever begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && mdl_data_q[(model_ptr + k) % N].size() > 0) g = (model_ptr + k) % N;
         end
         if (g < 0) break;
         exp_q.push_back(W'(g)); exp_last_q.push_back(1'b0); exp_gnt_q.push_back(g);
         do begin
            last = mdl_last_q[g].pop_front();
            exp_q.push_back(mdl_data_q[g].pop_front());
            exp_last_q.push_back(last);
            exp_gnt_q.push_back(g);
         end while (!last);
         model_ptr = (g + 1) % N;
      end
   endtask

   // One clock: drive sources, settle, check, pop accepted beats, advance.
   task automatic step();
      bit v;
      bit hs;
      for (int i = 0; i < N; i++) begin
         if (src_data_q[i].size() > 0) begin
            v = port_hold[i] || port_sop[i] || !bubble_en || ($urandom_range(0, 3) != 0);
            if (!port_hold[i] && i == gap_port && gap_cnt > 0) v = 1'b0;
            s_if.tvalid[i]          = v;
            s_if.tdata[i*W +: W]    = src_data_q[i][0];
            s_if.tlast[i]           = src_last_q[i][0];
         end else begin
            s_if.tvalid[i]          = 1'b0;
            s_if.tdata[i*W +: W]    = '0;
            s_if.tlast[i]           = 1'b0;
         end
      end
      case (tready_mode)
         0:       m_if.tready[0] = 1'b1;
         1:       m_if.tready[0] = ($urandom_range(0, 3) != 0);
         default: begin m_if.tready[0] = toggle; toggle = !toggle; end
      endcase
      #4;
      busy_cycles += int'(busy);
      if (gap_port >= 0 && gap_cnt > 0) begin
         check("gap_m_tvalid", m_if.tvalid[0], 0);
         check("gap_grant_id", grant_id, gap_port);
         gap_cnt--;
      end
      if (exp_gnt_q.size() > 0)
         check("s_tready_mask", s_if.tready & ~(N'(1) << exp_gnt_q[0]), 0);
      else
         check("s_tready_idle", s_if.tready, 0);
      if (stall_prev) begin
         check("stall_tvalid", m_if.tvalid[0], 1);
         check("stall_tdata", m_if.tdata, prev_data);
         check("stall_tlast", m_if.tlast[0], prev_last);
      end
      hs = m_if.tvalid[0] && m_if.tready[0];
      if (hs) begin
         out_count++;
         obs_gnt_q.push_back(int'(grant_id));
         if (exp_q.size() == 0) begin
            check("extra_beat", hs, 0);
         end else begin
            check("out_tdata", m_if.tdata, exp_q.pop_front());
            check("out_tlast", m_if.tlast[0], exp_last_q.pop_front());
            check("out_grant", grant_id, exp_gnt_q.pop_front());
         end
      end
      stall_prev = m_if.tvalid[0] && !m_if.tready[0];
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast[0];
      for (int i = 0; i < N; i++) begin
         port_hold[i] = s_if.tvalid[i] && !s_if.tready[i];
         if (s_if.tvalid[i] && s_if.tready[i]) begin
            rdy_cnt[i]++;
            void'(src_data_q[i].pop_front());
            port_sop[i] = src_last_q[i].pop_front();
            if (i == gap_port && gap_arm && !port_sop[i]) begin
               gap_cnt = 5;
               gap_arm = 1'b0;
            end
         end
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      clear_all();
      model_ptr = 0;
      s2_if.tvalid = '0; s2_if.tlast = '0; s2_if.tdata = '0; m2_if.tready = '0;
      repeat (2) @(posedge aclk);
      #4;
      check("rst_m_tvalid", m_if.tvalid[0], 0);
      check("rst_m_tlast", m_if.tlast[0], 0);
      check("rst_m_tdata", m_if.tdata, 0);
      check("rst_s_tready", s_if.tready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_state", state_dbg, ST_IDLE);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [W-1:0] d2[2];
      int           cnt;
      int           idx;

      aresetn = 1'b0;
      bubble_en = 1'b0;
      tready_mode = 0;
      do_reset();

      // Port 2, three beats, always ready: header 0x2 then A,B,C.
      add_packet(2, 3);
      build_expected();
      busy_cycles = 0;
      run_until_done("p2_pkt", 50);
      check("p2_busy_cycles", busy_cycles, 4);
      step();
      check("p2_busy_after", busy, 0);
      check("p2_grant_id", grant_id, 2);

      // All four ports with single-beat packets: rotation 0,1,2,3,0,1,2,3.
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < N; p++) add_packet(p, 1);
      build_expected();
      run_until_done("rr_rot", 100);
      for (int p = 0; p < N; p++) check($sformatf("rr_ready_pulses_p%0d", p), rdy_cnt[p], 2);
      check("rr_first_grant", obs_gnt_q[0], 0);
      check("rr_fifth_grant", obs_gnt_q[8], 0);

      // Port 1 with m_tready toggling: no loss/duplication, stable while stalled.
      do_reset();
      tready_mode = 2;
      add_packet(1, 4);
      build_expected();
      run_until_done("toggle", 60);
      check("toggle_beats", out_count, 5);
      tready_mode = 0;

      // Port 0 stalls 5 cycles mid-packet while port 3 waits.
      do_reset();
      add_packet(0, 4);
      add_packet(3, 2);
      gap_port = 0;
      gap_arm  = 1'b1;
      build_expected();
      run_until_done("gap", 80);
      check("gap_order_first", obs_gnt_q[0], 0);
      check("gap_order_second", obs_gnt_q[5], 3);
      gap_port = -1;

      // Reset during beat 2 of a 4-beat packet on port 0.
      do_reset();
      add_packet(0, 4);
      add_packet(2, 2);
      build_expected();
      idx = 0;
      while (out_count < 2 && idx < 40) begin step(); idx++; end
      check("midrst_reached", out_count, 2);
      aresetn = 1'b0;
      #2;
      check("midrst_m_tvalid", m_if.tvalid[0], 0);
      check("midrst_m_tlast", m_if.tlast[0], 0);
      check("midrst_m_tdata", m_if.tdata, 0);
      check("midrst_s_tready", s_if.tready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_grant_id", grant_id, 0);
      clear_all();
      model_ptr = 0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      step();
      step();
      add_packet(3, 2);
      add_packet(1, 1);
      build_expected();
      run_until_done("post_rst", 60);
      check("post_rst_first_grant", obs_gnt_q[0], 1);

      // Randomized traffic: bubbles mid-packet, random m_tready, two rounds.
      do_reset();
      bubble_en = 1'b1;
      tready_mode = 1;
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < N; p++) begin
            if ($urandom_range(0, 4) != 0) begin
               int np = $urandom_range(1, 4);
               for (int k = 0; k < np; k++) add_packet(p, $urandom_range(1, 5));
            end
         end
         build_expected();
         run_until_done($sformatf("rand_r%0d", r), 3000);
      end
      bubble_en = 1'b0;
      tready_mode = 0;

      // Headerless instance: port 3 sends two beats, exactly two come out.
      d2[0] = $urandom;
      d2[1] = $urandom;
      cnt = 0;
      idx = 0;
      m2_if.tready[0] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (idx < 2) begin
            s2_if.tvalid = 4'b1000;
            s2_if.tdata[3*W +: W] = d2[idx];
            s2_if.tlast = (idx == 1) ? 4'b1000 : 4'b0000;
         end else begin
            s2_if.tvalid = '0;
            s2_if.tlast  = '0;
         end
         #4;
         if (c == 0) check("nohdr_arb_cycle", m2_if.tvalid[0], 0);
         check("nohdr_ready_mask", s2_if.tready & 4'b0111, 0);
         if (m2_if.tvalid[0] && m2_if.tready[0]) begin
            if (cnt < 2) begin
               check($sformatf("nohdr_tdata%0d", cnt), m2_if.tdata, d2[cnt]);
               check($sformatf("nohdr_tlast%0d", cnt), m2_if.tlast[0], (cnt == 1));
               check("nohdr_grant", grant_id2, 3);
            end else begin
               check("nohdr_extra", m2_if.tvalid[0] && m2_if.tready[0], 0);
            end
            cnt++;
         end
         if (s2_if.tvalid[3] && s2_if.tready[3]) idx++;
         @(posedge aclk);
         #1;
      end
      check("nohdr_beat_count", cnt, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_uart_tx_arbiter.md
AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of AXI-stream requesters; legal range 2..16.
REQ-002 Parameter AXI_DATA_WIDTH, default 32: tdata width of every port.
REQ-003 Parameter ID_HEADER, default 1: 1 prepends one header beat carrying the source index to each packet; 0 disables it.
REQ-004 aclk  input  1  single clock for all logic.
REQ-005 aresetn  input  1  reset, asynchronous assertion, active-low.
REQ-006 s_tdata  input  NUM_PORTS*AXI_DATA_WIDTH  requester data, port i at bits [i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
REQ-007 s_tvalid  input  NUM_PORTS  requester valid, one bit per port.
REQ-008 s_tlast  input  NUM_PORTS  requester end-of-packet, one bit per port.
REQ-009 s_tready  output  NUM_PORTS  requester ready, one bit per port.
REQ-010 m_tdata  output  AXI_DATA_WIDTH  data to the UART transmitter slave stream.
REQ-011 m_tvalid  output  1  output valid.
REQ-012 m_tlast  output  1  output end-of-packet.
REQ-013 m_tready  input  1  transmitter ready.
REQ-014 grant_id  output  $clog2(NUM_PORTS)  index of the currently or most recently granted port.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL use the FSM states IDLE, HEADER and DATA.
REQ-017 IDLE: if any s_tvalid bit is high, the block SHALL grant the first requesting port found searching upward, with wrap-around, from (last grant + 1) mod NUM_PORTS, then go to HEADER if ID_HEADER=1, else to DATA.
REQ-018 Arbitration SHALL take exactly one cycle in IDLE; no beat transfers in the cycle where the grant is made.
REQ-019 HEADER: m_tvalid=1, m_tdata = grant_id zero-extended, m_tlast=0, all s_tready=0; on m_tready=1 the block SHALL go to DATA.
REQ-020 DATA: m_tdata, m_tvalid and m_tlast SHALL follow the granted port combinationally; s_tready[grant]=m_tready; every other s_tready bit SHALL be 0.
REQ-021 DATA: a beat with m_tvalid & m_tready & m_tlast SHALL return the FSM to IDLE in the next cycle.
REQ-022 The grant SHALL be held for a whole packet; s_tvalid changes on other ports SHALL NOT affect the grant.
REQ-023 If the granted port drops s_tvalid mid-packet, the block SHALL stay in DATA with m_tvalid=0 and keep the grant.
REQ-024 In IDLE, m_tvalid=0, m_tlast=0 and s_tready=0.
REQ-025 The round-robin pointer SHALL update only at the grant; with all ports requesting, grants SHALL rotate 0,1,...,NUM_PORTS-1,0.
REQ-026 A single-beat packet (tlast on the first beat) SHALL be accepted; it gives 2 output beats with header and 1 without.
REQ-027 Once m_tvalid is asserted, m_tdata and m_tlast SHALL stay stable until m_tready (AXI-stream rule); this holds if the upstream port obeys the same rule.

Reset
REQ-028 While aresetn=0 the FSM SHALL be IDLE, grant_id=0, the pointer SHALL select port 0 as highest priority, busy=0, m_tvalid=0, m_tlast=0, m_tdata=0 and s_tready=0.
REQ-029 A reset mid-packet SHALL abort the packet immediately, with no further beats driven after release.
REQ-030 After release, the first arbitration SHALL happen no earlier than the first rising edge with aresetn=1.

Structure
REQ-031 The FSM state enum (IDLE, HEADER, DATA) SHALL be defined in the shared UART package beside the transceiver parameters.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req[NUM_PORTS] and pointer, and outputs grant index and valid; the rest SHALL be one module.

Verification
REQ-033 NUM_PORTS=4, ID_HEADER=1, port 2 sends a 3-beat packet A,B,C, m_tready=1 -> output 0x2,A,B,C with tlast on C; busy high 4 cycles; grant_id=2.
REQ-034 All 4 ports hold 1-beat packets continuously -> grant sequence 0,1,2,3,0; each port receives exactly one s_tready pulse per round.
REQ-035 Port 1 granted, m_tready toggles 1,0,1,0 -> no beat lost or duplicated; m_tdata stable while m_tready=0.
REQ-036 Port 0 drops s_tvalid for 5 cycles mid-packet while port 3 requests -> grant stays 0 until port 0 tlast, then port 3 is granted.
REQ-037 aresetn pulled low during beat 2 of a 4-beat packet -> all outputs take reset values at once; after release, the next grant goes to the lowest requesting index.
REQ-038 ID_HEADER=0, port 3 sends 2 beats -> exactly 2 output beats, with no header.
